// File: rtl/rgbled_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// rgbled_frame_scheduler_if : word stream from scheduler to LED serializer
// Revision: 1.0
// ============================================================================
interface rgbled_frame_scheduler_if #(
    parameter int BITS_PER_LED = 24
);
    logic [BITS_PER_LED-1:0] led_word;
    logic                    led_valid;
    logic                    led_ready;
    logic                    ser_idle;

    modport master (
        output led_word,
        output led_valid,
        input  led_ready,
        input  ser_idle
    );

    modport slave (
        input  led_word,
        input  led_valid,
        output led_ready,
        output ser_idle
    );
endinterface
`default_nettype wire

// File: rtl/rgbled_frame_scheduler.sv
`default_nettype none
// ============================================================================
// rgbled_frame_scheduler : double-buffers SPI frames, streams LED words to the
// serializer, enforces the latch gap and optionally refreshes the chain.
// Revision: 1.0
// ============================================================================
module rgbled_frame_scheduler #(
    parameter int LEDS           = 10,
    parameter int BITS_PER_LED   = 24,
    parameter int RESET_CYCLES   = 1500,
    parameter int REFRESH_CYCLES = 0
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic [LEDS*BITS_PER_LED-1:0] frame_data,
    input  wire logic                         frame_rdy,
    rgbled_frame_scheduler_if.master          led,
    output logic                              busy,
    output logic [7:0]                        frame_count,
    output logic                              overrun
);

    localparam int FRAME_W = LEDS * BITS_PER_LED;
    localparam int IDX_W   = (LEDS > 1) ? $clog2(LEDS) : 1;
    localparam int LAT_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit REF_EN  = (REFRESH_CYCLES > 0);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t             state;
    logic [2:0]         rdy_sync;
    logic               rdy_edge;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] work;
    logic               pending;
    logic [IDX_W-1:0]   index;
    logic [LAT_W-1:0]   latch_cnt;
    logic [REF_W-1:0]   refresh_cnt;

    // Word 0 is the most significant slice of the frame.
    function automatic logic [BITS_PER_LED-1:0] word_at(
        input logic [FRAME_W-1:0] frame,
        input logic [IDX_W-1:0]   k
    );
        logic [FRAME_W-1:0] shifted;
        shifted = frame >> (BITS_PER_LED * (LEDS - 1 - int'(k)));
        return shifted[BITS_PER_LED-1:0];
    endfunction

    // Two flops resynchronise frame_rdy; the third holds the previous level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_sync <= 3'b000;
        end else begin
            rdy_sync <= {rdy_sync[1:0], frame_rdy};
        end
    end

    assign rdy_edge = rdy_sync[1] & ~rdy_sync[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            shadow        <= '0;
            work          <= '0;
            pending       <= 1'b0;
            index         <= '0;
            latch_cnt     <= '0;
            refresh_cnt   <= '0;
            led.led_word  <= '0;
            led.led_valid <= 1'b0;
            busy          <= 1'b0;
            frame_count   <= 8'd0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (pending) begin
                        work          <= shadow;
                        pending       <= 1'b0;
                        index         <= '0;
                        refresh_cnt   <= '0;
                        led.led_word  <= word_at(shadow, '0);
                        led.led_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= SEND;
                    end else if (REF_EN && (refresh_cnt == REF_LAST)) begin
                        index         <= '0;
                        refresh_cnt   <= '0;
                        led.led_word  <= word_at(work, '0);
                        led.led_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= SEND;
                    end else if (REF_EN) begin
                        refresh_cnt <= refresh_cnt + 1'b1;
                    end
                end

                SEND: begin
                    if (led.led_valid && led.led_ready) begin
                        if (index == LAST_IDX) begin
                            led.led_valid <= 1'b0;
                            state         <= DRAIN;
                        end else begin
                            index        <= index + 1'b1;
                            led.led_word <= word_at(work, index + 1'b1);
                        end
                    end
                end

                DRAIN: begin
                    if (led.ser_idle) begin
                        latch_cnt <= '0;
                        state     <= LATCH;
                    end
                end

                LATCH: begin
                    if (latch_cnt == LAT_LAST) begin
                        frame_count <= frame_count + 8'd1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end

                default: begin
                    led.led_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase

            // Placed last so a new arrival re-arms pending even on the cycle
            // IDLE consumes the previous one; the newest frame always wins.
            if (rdy_edge) begin
                shadow  <= frame_data;
                pending <= 1'b1;
                overrun <= pending;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgbled_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_rgbled_frame_scheduler : directed, table-driven bench for the scheduler
// Revision: 1.0
// ============================================================================
module tb_rgbled_frame_scheduler;

    localparam int LEDS     = 3;
    localparam int BPL      = 8;
    localparam int LATCH_N  = 4;
    localparam int SER_TAIL = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] frame_data_a = '0;
    logic        frame_rdy_a = 1'b0;
    logic        busy_a;
    logic [7:0]  fc_a;
    logic        ovr_a;
    logic [23:0] frame_data_b = '0;
    logic        frame_rdy_b = 1'b0;
    logic        busy_b;
    logic [7:0]  fc_b;
    logic        ovr_b;

    int checks = 0;
    int failures = 0;

    rgbled_frame_scheduler_if #(.BITS_PER_LED(BPL)) ia ();
    rgbled_frame_scheduler_if #(.BITS_PER_LED(BPL)) ib ();

    rgbled_frame_scheduler #(
        .LEDS(LEDS), .BITS_PER_LED(BPL), .RESET_CYCLES(LATCH_N), .REFRESH_CYCLES(0)
    ) dut_a (
        .clk(clk), .reset(reset), .frame_data(frame_data_a), .frame_rdy(frame_rdy_a),
        .led(ia.master), .busy(busy_a), .frame_count(fc_a), .overrun(ovr_a)
    );

    rgbled_frame_scheduler #(
        .LEDS(LEDS), .BITS_PER_LED(BPL), .RESET_CYCLES(LATCH_N), .REFRESH_CYCLES(20)
    ) dut_b (
        .clk(clk), .reset(reset), .frame_data(frame_data_b), .frame_rdy(frame_rdy_b),
        .led(ib.master), .busy(busy_b), .frame_count(fc_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;

    // Serializer model for A: line stays busy SER_TAIL cycles after each word.
    logic [1:0] tail_a;
    always @(posedge clk) begin
        if (reset) tail_a <= 2'd0;
        else if (ia.led_valid && ia.led_ready) tail_a <= 2'(SER_TAIL);
        else if (tail_a != 2'd0) tail_a <= tail_a - 2'd1;
    end
    assign ia.ser_idle = (tail_a == 2'd0);
    assign ib.ser_idle = 1'b1;
    assign ib.led_ready = 1'b1;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         ovr_cnt_a = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_word = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ia.led_valid && ia.led_ready) qa.push_back(ia.led_word);
            if (ib.led_valid && ib.led_ready) qb.push_back(ib.led_word);
            if (prev_valid && !prev_ready && ia.led_valid)
                check("stall_hold", 32'(ia.led_word), 32'(prev_word));
            if (ovr_a) ovr_cnt_a++;
        end
        prev_valid = ia.led_valid && !reset;
        prev_ready = ia.led_ready;
        prev_word  = ia.led_word;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic send_a(input logic [23:0] d);
        frame_data_a = d;
        frame_rdy_a  = 1'b1;
        repeat (4) step();
        frame_rdy_a  = 1'b0;
    endtask

    task automatic wait_words_a(input int target);
        int n = 0;
        while (qa.size() < target && n < 200) begin step(); n++; end
        if (qa.size() < target) check("timeout_words_a", 32'(qa.size()), 32'(target));
    endtask

    task automatic wait_fc(input bit sel, input logic [7:0] target);
        int n = 0;
        while (((sel ? fc_b : fc_a) != target) && n < 300) begin step(); n++; end
        if ((sel ? fc_b : fc_a) != target)
            check(sel ? "timeout_fc_b" : "timeout_fc_a", 32'(sel ? fc_b : fc_a), 32'(target));
    endtask

    typedef struct {
        logic [23:0] data;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [7:0]  w2;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int base;
        int n;
        logic [7:0] pat[6];

        tbl[0] = '{24'hA1B2C3, 8'hA1, 8'hB2, 8'hC3};
        tbl[1] = '{24'h00FF5A, 8'h00, 8'hFF, 8'h5A};
        tbl[2] = '{24'h123456, 8'h12, 8'h34, 8'h56};
        tbl[3] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF};
        pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};

        ia.led_ready = 1'b1;
        do_reset();

        check("reset_valid", 32'(ia.led_valid), 32'd0);
        check("reset_word", 32'(ia.led_word), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_fc", 32'(fc_a), 32'd0);
        check("reset_ovr", 32'(ovr_a), 32'd0);

        // Table-driven frames with the always-ready serializer.
        for (int i = 0; i < 4; i++) begin
            base = qa.size();
            send_a(tbl[i].data);
            wait_words_a(base + 3);
            check("valid_drop", 32'(ia.led_valid), 32'd0);
            n = 0;
            while (busy_a && n < 50) begin n++; step(); end
            check("drain_latch_cycles", 32'(n), 32'(SER_TAIL + 1 + LATCH_N));
            if (qa.size() >= base + 3) begin
                check("word0", 32'(qa[base]), 32'(tbl[i].w0));
                check("word1", 32'(qa[base+1]), 32'(tbl[i].w1));
                check("word2", 32'(qa[base+2]), 32'(tbl[i].w2));
            end
            check("frame_count", 32'(fc_a), 32'(i + 1));
            check("overrun_none", 32'(ovr_cnt_a), 32'd0);
            repeat (3) step();
        end

        // No refresh configured: the line must stay quiet.
        base = qa.size();
        repeat (200) step();
        check("no_refresh_words", 32'(qa.size()), 32'(base));
        check("no_refresh_busy", 32'(busy_a), 32'd0);

        // Backpressure: words must hold while stalled.
        do_reset();
        qa.delete();
        ia.led_ready = 1'b0;
        send_a(24'hC0FFEE);
        check("bp_valid_up", 32'(ia.led_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            ia.led_ready = pat[i][0];
            step();
        end
        ia.led_ready = 1'b1;
        repeat (20) step();
        check("bp_count", 32'(qa.size()), 32'd3);
        if (qa.size() == 3) begin
            check("bp_w0", 32'(qa[0]), 32'hC0);
            check("bp_w1", 32'(qa[1]), 32'hFF);
            check("bp_w2", 32'(qa[2]), 32'hEE);
        end

        // Two frames arrive while the first is still in SEND.
        do_reset();
        qa.delete();
        ovr_cnt_a = 0;
        ia.led_ready = 1'b0;
        send_a(24'h112233);
        ia.led_ready = 1'b1;
        step();
        ia.led_ready = 1'b0;
        repeat (4) step();
        send_a(24'h445566);
        repeat (4) step();
        send_a(24'h778899);
        repeat (4) step();
        check("mid_in_send", 32'(ia.led_valid), 32'd1);
        ia.led_ready = 1'b1;
        wait_fc(1'b0, 8'd2);
        check("mid_count", 32'(qa.size()), 32'd6);
        if (qa.size() == 6) begin
            check("mid_w0", 32'(qa[0]), 32'h11);
            check("mid_w1", 32'(qa[1]), 32'h22);
            check("mid_w2", 32'(qa[2]), 32'h33);
            check("mid_w3", 32'(qa[3]), 32'h77);
            check("mid_w4", 32'(qa[4]), 32'h88);
            check("mid_w5", 32'(qa[5]), 32'h99);
        end
        check("mid_overrun", 32'(ovr_cnt_a), 32'd1);
        check("mid_fc", 32'(fc_a), 32'd2);

        // Reset right after the first transfer aborts the frame.
        repeat (3) step();
        base = qa.size();
        send_a(24'h5A5AA5);
        step();
        check("abort_first_xfer", 32'(qa.size()), 32'(base + 1));
        ia.led_ready = 1'b0;
        reset = 1'b1;
        step();
        check("abort_valid", 32'(ia.led_valid), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_fc", 32'(fc_a), 32'd0);
        reset = 1'b0;
        ia.led_ready = 1'b1;
        repeat (30) step();
        check("abort_quiet", 32'(qa.size()), 32'(base + 1));
        check("abort_idle", 32'(busy_a), 32'd0);

        // Periodic refresh on the second instance.
        do_reset();
        qb.delete();
        frame_data_b = 24'h0A0B0C;
        frame_rdy_b  = 1'b1;
        repeat (4) step();
        frame_rdy_b  = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            wait_fc(1'b1, 8'(r));
            check("ref_words", 32'(qb.size()), 32'(3 * r));
            if (qb.size() == 3 * r) begin
                check("ref_w0", 32'(qb[3*r-3]), 32'h0A);
                check("ref_w1", 32'(qb[3*r-2]), 32'h0B);
                check("ref_w2", 32'(qb[3*r-1]), 32'h0C);
            end
            n = 0;
            while (!busy_b && n < 100) begin n++; step(); end
            check("ref_gap", 32'(n), 32'd20);
        end

        // 256 frames wrap the frame counter.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_a(24'(i * 24'h010101));
            repeat (4) step();
            wait_fc(1'b0, 8'(i + 1));
            if (i == 254) check("wrap_255", 32'(fc_a), 32'd255);
        end
        check("wrap_zero", 32'(fc_a), 32'd0);
        check("wrap_idle", 32'(busy_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
